stopwatch: RTL
==============

# stopwatch

Interval-measurement companion to the countdown timer: where the timer waits a requested number of cycles, this block measures how many cycles actually elapse between a start event and a stop event. It reports each measured interval through a registered valid/ready result port, clamping at full scale and flagging saturation. It sits beside timer instances in the design and is used to time handshakes, latency checks and timeout calibration.

## Interface
- WIDTH, 8, width of the elapsed-cycle counter and result; minimum 2
- clk_i  input  1  system clock
- rst_i  input  1  reset; one clock; reset is synchronous and active-high
- start_i  input  1  begin (or restart) a measurement
- stop_i  input  1  end the running measurement and emit a result
- lap_i  input  1  emit an intermediate result without stopping (see Configuration)
- ready_i  input  1  consumer accepts the result when high with valid_o
- elapsed_o  output  WIDTH  measured cycles, clamped to 2^WIDTH-1
- sat_o  output  1  result was clamped (true interval ≥ 2^WIDTH)
- lap_o  output  1  result came from lap_i, not stop_i
- valid_o  output  1  result register holds an unconsumed result
- running_o  output  1  measurement in progress
- drop_o  output  1  one-cycle pulse: a result was discarded because the slot was full

## Operation
- States: IDLE, RUNNING. running_o = (state == RUNNING).
- Per-edge priority: rst_i > start_i > stop_i > lap_i.
- rst_i: state IDLE, count 0, sticky-sat 0, valid_o 0, all result outputs 0, drop_o 0. Any pending result is discarded.
- start_i (either state): count ← 0, sticky-sat ← 0, state ← RUNNING. A stop_i/lap_i on the same edge is ignored; a running measurement is aborted with no result.
- RUNNING, no event: count ← count+1; if count is all-ones, count holds and sticky-sat ← 1.
- stop_i in RUNNING: candidate result = count+1 (clamped), sat = sticky-sat OR (count all-ones), lap = 0; state ← IDLE.
- lap_i in RUNNING (macro on): same candidate with lap = 1; state stays RUNNING, count increments as normal.
- stop_i / lap_i in IDLE: ignored, no result, no drop.
- Result slot: candidate loads into elapsed_o/sat_o/lap_o and valid_o ← 1 if valid_o is 0 or (valid_o && ready_i) on that edge. Otherwise candidate discarded, drop_o pulses 1 on the next cycle, held result unchanged.
- valid_o && ready_i with no new candidate: valid_o ← 0; elapsed_o/sat_o/lap_o hold last value.
- Result outputs stable while valid_o && !ready_i.

## Timing
- Convention matches the timer: start sampled at edge T, stop sampled at edge T+N → elapsed_o = N (N ≥ 1).
- Result latency: valid_o and result fields are registered, visible the cycle after the stop/lap edge.
- running_o rises the cycle after the start edge, falls the cycle after the stop edge.
- Clamping: N ≤ 2^WIDTH-1 → elapsed_o = N, sat_o = 0; N ≥ 2^WIDTH → elapsed_o = 2^WIDTH-1, sat_o = 1.
- Back-to-back: stop at edge S and start at edge S+1 is legal; minimum measurable interval is 1.
- All outputs reset to 0; reset mid-run or mid-handshake takes effect on that edge with no result and no drop_o.

## Configuration
- STOPWATCH_LAP_EN defined: lap_i behaves as above; lap_o reports lap origin.
- Not defined: lap_i ignored in all states, lap_o tied 0, no lap logic synthesised; ports remain for interface stability.

## Test plan
- WIDTH=8, ready_i=1: start at edge 0, stop at edge 25 → valid_o one cycle after edge 25, elapsed_o=25, sat_o=0, lap_o=0, running_o 0 afterwards.
- WIDTH=8: stop at N=255 → elapsed_o=255, sat_o=0; rerun with N=300 → elapsed_o=255, sat_o=1.
- ready_i=0: two measurements (N=10, then N=7) → elapsed_o stays 10, drop_o pulses once after second stop; ready_i=1 → valid_o falls next cycle.
- Simultaneous events: start+stop same edge while RUNNING → no result, count restarts at 0; stop in IDLE → no valid_o, no drop_o.
- Reset: rst_i at edge 12 of a run with a pending unconsumed result → valid_o=0, running_o=0, all outputs 0 next cycle; later stop_i produces nothing.
- STOPWATCH_LAP_EN: start edge 0, lap edge 5, stop edge 9 (ready_i=1) → results 5 (lap_o=1) then 9 (lap_o=0); without macro, only 9.

Source files
------------

// File: rtl/stopwatch_if.sv
// stopwatch_if -- result port of the stopwatch.
//
// Carries one measured interval from the stopwatch (master) to its consumer
// (slave) with a valid/ready handshake.
//   elapsed_o  WIDTH  measured cycles, clamped to 2^WIDTH-1
//   sat_o      1      result was clamped
//   lap_o      1      result came from a lap event rather than a stop
//   valid_o    1      result register holds an unconsumed result
//   ready_i    1      consumer accepts the result when high with valid_o
interface stopwatch_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] elapsed_o;
  logic             sat_o;
  logic             lap_o;
  logic             valid_o;
  logic             ready_i;

  modport master (
    output elapsed_o,
    output sat_o,
    output lap_o,
    output valid_o,
    input  ready_i
  );

  modport slave (
    input  elapsed_o,
    input  sat_o,
    input  lap_o,
    input  valid_o,
    output ready_i
  );
endinterface

// File: rtl/stopwatch.sv
// stopwatch -- measures the number of cycles between a start event and a
// stop (or lap) event and reports it through a registered valid/ready slot.
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   start_i    begin or restart a measurement (aborts a running one silently)
//   stop_i     end the running measurement and emit a result
//   lap_i      emit an intermediate result without stopping
//   running_o  measurement in progress
//   drop_o     one-cycle pulse: a result was discarded because the slot was full
//   res        result port (stopwatch_if.master): elapsed_o, sat_o, lap_o,
//              valid_o, ready_i
//
// Build option: define STOPWATCH_LAP_EN to enable lap results. Without it
// lap_i is ignored and lap_o is tied low.
//
// Timing: start sampled at edge T and stop at edge T+N gives elapsed_o = N.
// The counter holds N-1 at the stop edge, so the result is count+1, clamped.
module stopwatch #(
  parameter int WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        lap_i,
  output logic        running_o,
  output logic        drop_o,
  stopwatch_if.master res
);

  typedef enum logic {IDLE, RUNNING} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             sticky_sat_reg, sticky_sat_next;

  logic [WIDTH-1:0] elapsed_reg, elapsed_next;
  logic             sat_reg, sat_next;
  logic             lap_reg, lap_next;
  logic             valid_reg, valid_next;
  logic             drop_reg, drop_next;

  logic             count_full;
  logic             stop_req;
  logic             lap_req;
  logic             cand_valid;
  logic             slot_free;
  logic [WIDTH-1:0] cand_elapsed;
  logic             cand_sat;

  // start_i dominates stop_i/lap_i on the same edge; both are ignored in IDLE.
  assign stop_req = (state_reg == RUNNING) && stop_i && !start_i;

`ifdef STOPWATCH_LAP_EN
  assign lap_req = (state_reg == RUNNING) && lap_i && !start_i && !stop_i;
`else
  // lap_i is kept for interface stability but folds to a constant.
  assign lap_req = lap_i & 1'b0;
`endif

  assign count_full   = &count_reg;
  assign cand_valid   = stop_req || lap_req;
  assign cand_elapsed = count_full ? count_reg : count_reg + WIDTH'(1);
  assign cand_sat     = sticky_sat_reg || count_full;
  // The slot can take a new result if empty or being drained on this edge.
  assign slot_free    = !valid_reg || res.ready_i;

  // ---- FSM: state register ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---- FSM: next-state logic ----
  always_comb begin
    state_next = state_reg;
    if (start_i) begin
      state_next = RUNNING;
    end else if (stop_req) begin
      state_next = IDLE;
    end
  end

  // ---- FSM: outputs ----
  always_comb begin
    running_o = (state_reg == RUNNING);
  end

  // ---- counter and sticky saturation ----
  always_comb begin
    count_next      = count_reg;
    sticky_sat_next = sticky_sat_reg;
    if (start_i) begin
      count_next      = '0;
      sticky_sat_next = 1'b0;
    end else if (state_reg == RUNNING && !stop_req) begin
      // Counter saturates at all-ones; the sticky bit remembers the overflow.
      if (count_full) begin
        sticky_sat_next = 1'b1;
      end else begin
        count_next = count_reg + WIDTH'(1);
      end
    end
  end

  // ---- result slot ----
  always_comb begin
    elapsed_next = elapsed_reg;
    sat_next     = sat_reg;
    lap_next     = lap_reg;
    valid_next   = valid_reg;
    drop_next    = 1'b0;
    if (valid_reg && res.ready_i) begin
      valid_next = 1'b0;
    end
    if (cand_valid) begin
      if (slot_free) begin
        elapsed_next = cand_elapsed;
        sat_next     = cand_sat;
        lap_next     = lap_req;
        valid_next   = 1'b1;
      end else begin
        drop_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_reg      <= '0;
      sticky_sat_reg <= 1'b0;
      elapsed_reg    <= '0;
      sat_reg        <= 1'b0;
      lap_reg        <= 1'b0;
      valid_reg      <= 1'b0;
      drop_reg       <= 1'b0;
    end else begin
      count_reg      <= count_next;
      sticky_sat_reg <= sticky_sat_next;
      elapsed_reg    <= elapsed_next;
      sat_reg        <= sat_next;
      lap_reg        <= lap_next;
      valid_reg      <= valid_next;
      drop_reg       <= drop_next;
    end
  end

  assign res.elapsed_o = elapsed_reg;
  assign res.sat_o     = sat_reg;
  assign res.valid_o   = valid_reg;
  assign drop_o        = drop_reg;

`ifdef STOPWATCH_LAP_EN
  assign res.lap_o = lap_reg;
`else
  assign res.lap_o = 1'b0;
`endif

endmodule
